// File: rtl/contact_pkg.sv
// Shared definitions for the contact collector: 288-bit record layout, FP constants
// and the output FSM state encoding.
package contact_pkg;

    localparam int CONTACT_W = 288;
    localparam int FIELD_W   = 32;

    localparam int CX_OFF    = 0;
    localparam int CY_OFF    = 32;
    localparam int CZ_OFF    = 64;
    localparam int NX_OFF    = 96;
    localparam int NY_OFF    = 128;
    localparam int NZ_OFF    = 160;
    localparam int DEPTH_OFF = 192;
    localparam int G1_OFF    = 224;
    localparam int G2_OFF    = 256;

    localparam logic [31:0] FP_ZERO = 32'h0000_0000;
    localparam logic [31:0] FP_ONE  = 32'h3F80_0000;

    typedef enum logic [1:0] {
        OUT_IDLE  = 2'd0,
        OUT_LOAD  = 2'd1,
        OUT_VALID = 2'd2
    } out_state_e;

    function automatic logic [CONTACT_W-1:0] pack_contact(
        input logic [31:0] cx, input logic [31:0] cy, input logic [31:0] cz,
        input logic [31:0] nx, input logic [31:0] ny, input logic [31:0] nz,
        input logic [31:0] dep, input logic [31:0] g1, input logic [31:0] g2);
        return {g2, g1, dep, nz, ny, nx, cz, cy, cx};
    endfunction

endpackage

// File: rtl/contact_ram.sv
// Simple dual-port record store: synchronous write, one-cycle registered read.
module contact_ram
    import contact_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int W     = CONTACT_W
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [DEPTH];

    // No reset on the array or read register so the block maps onto embedded RAM.
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/contact_collector.sv
// Captures contacts from the sphere-sphere collision unit on each done rising edge,
// queues them in a small FIFO and presents them over valid/ready with debug statistics.
module contact_collector
    import contact_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          done,
    input  logic          ret,
    input  logic [31:0]   cx,
    input  logic [31:0]   cy,
    input  logic [31:0]   cz,
    input  logic [31:0]   normalx,
    input  logic [31:0]   normaly,
    input  logic [31:0]   normalz,
    input  logic [31:0]   depth,
    input  logic [31:0]   g1,
    input  logic [31:0]   g2,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_cx,
    output logic [31:0]   out_cy,
    output logic [31:0]   out_cz,
    output logic [31:0]   out_nx,
    output logic [31:0]   out_ny,
    output logic [31:0]   out_nz,
    output logic [31:0]   out_depth,
    output logic [31:0]   out_g1,
    output logic [31:0]   out_g2,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic          overflow,
    output logic [15:0]   pairs_seen,
    output logic [15:0]   hits_seen
);

    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic                 done_q;
    logic                 cap_ev;
    logic                 store;
    logic                 drop;
    logic                 pop;
    logic                 rd_en;
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q;
    logic [AW:0]          count_q, count_d;
    logic [15:0]          pairs_q, hits_q;
    logic                 ovf_q;
    out_state_e           state_q;
    logic                 out_valid_q;
    logic [CONTACT_W-1:0] out_rec_q;
    logic [CONTACT_W-1:0] ram_rdata;

    // Clear wins over a same-edge capture: that event is neither stored nor counted.
    assign cap_ev   = done & ~done_q & ~clear;
    assign full     = (count_q == CNT_FULL);
    assign empty    = (count_q == '0);
    assign store    = cap_ev & ret & ~full;
    assign drop     = cap_ev & ret & full;
    assign pop      = out_valid_q & out_ready;
    assign wr_ptr_d = store ? wr_ptr_q + PTR_ONE : wr_ptr_q;

    always_comb begin
        count_d = count_q;
        case ({store, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // count includes the head record, so more unread data exists when count exceeds one.
    always_comb begin
        rd_en = 1'b0;
        if (!clear) begin
            if (state_q == OUT_IDLE)       rd_en = (count_q != '0);
            else if (state_q == OUT_VALID) rd_en = pop && (count_q > CNT_ONE);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_q   <= 1'b0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            pairs_q  <= '0;
            hits_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            done_q <= done;
            if (clear) begin
                wr_ptr_q <= '0;
                count_q  <= '0;
                pairs_q  <= '0;
                hits_q   <= '0;
                ovf_q    <= 1'b0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                count_q  <= count_d;
                if (cap_ev)       pairs_q <= pairs_q + 16'd1;
                if (cap_ev & ret) hits_q  <= hits_q + 16'd1;
                if (drop)         ovf_q   <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= OUT_IDLE;
            out_valid_q <= 1'b0;
            rd_ptr_q    <= '0;
            out_rec_q   <= '0;
        end else if (clear) begin
            state_q     <= OUT_IDLE;
            out_valid_q <= 1'b0;
            rd_ptr_q    <= '0;
        end else begin
            case (state_q)
                OUT_IDLE: if (rd_en) state_q <= OUT_LOAD;
                OUT_LOAD: begin
                    out_rec_q   <= ram_rdata;
                    rd_ptr_q    <= rd_ptr_q + PTR_ONE;
                    out_valid_q <= 1'b1;
                    state_q     <= OUT_VALID;
                end
                OUT_VALID: if (pop) begin
                    out_valid_q <= 1'b0;
                    state_q     <= rd_en ? OUT_LOAD : OUT_IDLE;
                end
                default: state_q <= OUT_IDLE;
            endcase
        end
    end

    contact_ram #(.DEPTH(DEPTH), .AW(AW), .W(CONTACT_W)) u_ram (
        .clk     (clk),
        .we_i    (store),
        .waddr_i (wr_ptr_q),
        .wdata_i (pack_contact(cx, cy, cz, normalx, normaly, normalz, depth, g1, g2)),
        .re_i    (rd_en),
        .raddr_i (rd_ptr_q),
        .rdata_o (ram_rdata)
    );

    assign out_valid  = out_valid_q;
    assign out_cx     = out_rec_q[CX_OFF    +: FIELD_W];
    assign out_cy     = out_rec_q[CY_OFF    +: FIELD_W];
    assign out_cz     = out_rec_q[CZ_OFF    +: FIELD_W];
    assign out_nx     = out_rec_q[NX_OFF    +: FIELD_W];
    assign out_ny     = out_rec_q[NY_OFF    +: FIELD_W];
    assign out_nz     = out_rec_q[NZ_OFF    +: FIELD_W];
    assign out_depth  = out_rec_q[DEPTH_OFF +: FIELD_W];
    assign out_g1     = out_rec_q[G1_OFF    +: FIELD_W];
    assign out_g2     = out_rec_q[G2_OFF    +: FIELD_W];
    assign count      = count_q;
    assign overflow   = ovf_q;
    assign pairs_seen = pairs_q;
    assign hits_seen  = hits_q;

endmodule

// File: tb/tb_contact_collector.sv
// Scoreboard bench for contact_collector: queue-based reference model, random and directed traffic.
module tb_contact_collector;
    import contact_pkg::*;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    typedef struct packed {
        logic [31:0] g2, g1, dp, nz, ny, nx, cz, cy, cx;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        done = 1'b0;
    logic        ret = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] cx = '0, cy = '0, cz = '0;
    logic [31:0] normalx = '0, normaly = '0, normalz = '0;
    logic [31:0] depth = '0, g1 = '0, g2 = '0;

    logic        out_valid;
    logic [31:0] out_cx, out_cy, out_cz, out_nx, out_ny, out_nz, out_depth, out_g1, out_g2;
    logic [AW:0] count;
    logic        full, empty, overflow;
    logic [15:0] pairs_seen, hits_seen;

    rec_t sb[$];
    int   pend = 0;
    int   m_pairs = 0;
    int   m_hits = 0;
    bit   m_ovf = 1'b0;
    int   checks = 0;
    int   failures = 0;

    contact_collector #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .clear(clear), .done(done), .ret(ret),
        .cx(cx), .cy(cy), .cz(cz),
        .normalx(normalx), .normaly(normaly), .normalz(normalz),
        .depth(depth), .g1(g1), .g2(g2),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_cx(out_cx), .out_cy(out_cy), .out_cz(out_cz),
        .out_nx(out_nx), .out_ny(out_ny), .out_nz(out_nz),
        .out_depth(out_depth), .out_g1(out_g1), .out_g2(out_g2),
        .count(count), .full(full), .empty(empty), .overflow(overflow),
        .pairs_seen(pairs_seen), .hits_seen(hits_seen)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic chk_rec(input string name, input rec_t got, input rec_t exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    function automatic rec_t rand_rec();
        rec_t r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom,
             $urandom, $urandom, $urandom, $urandom};
        return r;
    endfunction

    // Drive a done rising edge for the next clock edge and update the reference model.
    task automatic issue(input logic r, input rec_t rc);
        done = 1'b1; ret = r;
        cx = rc.cx; cy = rc.cy; cz = rc.cz;
        normalx = rc.nx; normaly = rc.ny; normalz = rc.nz;
        depth = rc.dp; g1 = rc.g1; g2 = rc.g2;
        m_pairs++;
        if (r) begin
            m_hits++;
            if (sb.size() < DEPTH) begin
                sb.push_back(rc);
                pend = 1;
            end else begin
                m_ovf = 1'b1;
            end
        end
    endtask

    task automatic capture(input logic r, input rec_t rc, input bit rnd_rdy);
        issue(r, rc);
        if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        done = 1'b0; pend = 0;
        if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
    endtask

    task automatic model_reset();
        sb.delete(); pend = 0; m_pairs = 0; m_hits = 0; m_ovf = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        model_reset();
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
        chk("wait_valid", 64'(out_valid), 64'd1);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 200 && (sb.size() != 0 || out_valid); i++) @(negedge clk);
        chk("drain_sb", 64'(sb.size()), 64'd0);
        chk("drain_count", 64'(count), 64'd0);
    endtask

    // Monitor: samples just after the falling edge, where inputs for the next edge are settled.
    rec_t prev_rec;
    bit   prev_hold = 1'b0;
    always begin
        rec_t cur;
        @(negedge clk);
        #1;
        cur = {out_g2, out_g1, out_depth, out_nz, out_ny, out_nx, out_cz, out_cy, out_cx};
        if (!rst || clear) begin
            prev_hold = 1'b0;
        end else begin
            chk("count_model", 64'(count), 64'(sb.size() - pend));
            if (prev_hold) begin
                chk("stable_valid", 64'(out_valid), 64'd1);
                chk_rec("stable_rec", cur, prev_rec);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("pop_nonempty", 64'(sb.size()), 64'd1);
                end else begin
                    chk_rec("pop_rec", cur, sb.pop_front());
                end
            end
            prev_hold = out_valid && !out_ready;
            prev_rec  = cur;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rec_t rc;
        #1 rst = 1'b0;
        #1;
        chk("rst_valid",    64'(out_valid),  64'd0);
        chk("rst_count",    64'(count),      64'd0);
        chk("rst_empty",    64'(empty),      64'd1);
        chk("rst_full",     64'(full),       64'd0);
        chk("rst_overflow", 64'(overflow),   64'd0);
        chk("rst_pairs",    64'(pairs_seen), 64'd0);
        chk("rst_hits",     64'(hits_seen),  64'd0);
        chk("rst_cx",       64'(out_cx),     64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Single contact with first-word latency
        out_ready = 1'b1;
        rc = '0; rc.cx = FP_ONE; rc.dp = 32'h4000_0000; rc.g1 = 32'd5;
        capture(1'b1, rc, 1'b0);
        chk("lat_t1_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("lat_t2_valid", 64'(out_valid), 64'd1);
        chk("single_g1",    64'(out_g1),    64'd5);
        chk("single_cx",    64'(out_cx),    64'(FP_ONE));
        chk("single_depth", 64'(out_depth), 64'h4000_0000);
        @(negedge clk);
        chk("single_popped", 64'(out_valid),  64'd0);
        chk("single_count",  64'(count),      64'd0);
        chk("single_pairs",  64'(pairs_seen), 64'd1);
        chk("single_hits",   64'(hits_seen),  64'd1);

        // Miss filtered
        do_clear();
        capture(1'b0, rand_rec(), 1'b0);
        repeat (3) @(negedge clk);
        chk("miss_empty", 64'(empty),      64'd1);
        chk("miss_pairs", 64'(pairs_seen), 64'd1);
        chk("miss_hits",  64'(hits_seen),  64'd0);

        // done held high for 50 cycles
        do_clear();
        issue(1'b1, rand_rec());
        @(negedge clk);
        pend = 0;
        repeat (49) @(negedge clk);
        done = 1'b0;
        repeat (5) @(negedge clk);
        chk("level_pairs", 64'(pairs_seen), 64'd1);
        chk("level_hits",  64'(hits_seen),  64'd1);
        chk("level_sb",    64'(sb.size()),  64'd0);

        // Overflow: 10 contacts into an 8-deep FIFO with no consumer
        do_clear();
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            rc = rand_rec(); rc.g1 = 32'(i + 1);
            capture(1'b1, rc, 1'b0);
        end
        chk("ovf_full",     64'(full),      64'd1);
        chk("ovf_count",    64'(count),     64'd8);
        chk("ovf_flag",     64'(overflow),  64'd1);
        chk("ovf_hits",     64'(hits_seen), 64'd10);
        chk("ovf_head_g1",  64'(out_g1),    64'd1);
        // Capture while full with a same-edge pop is still dropped
        out_ready = 1'b1;
        issue(1'b1, rand_rec());
        @(negedge clk);
        done = 1'b0; pend = 0; out_ready = 1'b0;
        chk("full_pop_count", 64'(count), 64'd7);
        drain();

        // Same-edge capture and pop at count 3
        do_clear();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) capture(1'b1, rand_rec(), 1'b0);
        wait_valid();
        chk("simul_pre", 64'(count), 64'd3);
        out_ready = 1'b1;
        issue(1'b1, rand_rec());
        @(negedge clk);
        done = 1'b0; pend = 0; out_ready = 1'b0;
        chk("simul_count", 64'(count), 64'd3);
        @(negedge clk);
        // clear on the same edge as a capture
        clear = 1'b1; done = 1'b1; ret = 1'b1;
        model_reset();
        @(negedge clk);
        clear = 1'b0; done = 1'b0;
        chk("clrcap_count", 64'(count),      64'd0);
        chk("clrcap_pairs", 64'(pairs_seen), 64'd0);
        chk("clrcap_valid", 64'(out_valid),  64'd0);
        repeat (3) @(negedge clk);

        // Asynchronous reset with 4 records queued
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) capture(1'b1, rand_rec(), 1'b0);
        wait_valid();
        #2 rst = 1'b0;
        #1;
        chk("arst_valid",    64'(out_valid),  64'd0);
        chk("arst_count",    64'(count),      64'd0);
        chk("arst_empty",    64'(empty),      64'd1);
        chk("arst_full",     64'(full),       64'd0);
        chk("arst_overflow", 64'(overflow),   64'd0);
        chk("arst_pairs",    64'(pairs_seen), 64'd0);
        chk("arst_hits",     64'(hits_seen),  64'd0);
        chk("arst_g1",       64'(out_g1),     64'd0);
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1; out_ready = 1'b1;
        repeat (10) @(negedge clk);
        chk("arst_no_stale", 64'(out_valid), 64'd0);
        chk("arst_empty2",   64'(empty),     64'd1);

        // Randomized traffic against the reference model
        for (int i = 0; i < 300; i++) begin
            capture(1'($urandom_range(0, 9) < 7), rand_rec(), 1'b1);
            repeat ($urandom_range(0, 2)) begin
                out_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
        end
        drain();
        chk("rand_pairs",    64'(pairs_seen), 64'(m_pairs[15:0]));
        chk("rand_hits",     64'(hits_seen),  64'(m_hits[15:0]));
        chk("rand_overflow", 64'(overflow),   64'(m_ovf));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
